// File: rtl/execute_stage.sv
// execute_stage: RV32 EX stage (forwarding, ALU, BEQ resolve, EX/MEM register); define EXECUTE_FWD_EN to honour HU_RS1/HU_RS2 bypass selects
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ALU_CONTROL,
  input  logic [1:0]  ALU_SRC2,
  input  logic        BRN_COND,
  input  logic        MEM_WE,
  input  logic        DE_WE,
  input  logic        MEM_REG,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic [24:0] Imm,
  input  logic [31:0] PC_EX,
  input  logic [1:0]  HU_RS1,
  input  logic [1:0]  HU_RS2,
  input  logic [31:0] BP_MEM,
  input  logic [31:0] BP_WB,
  output logic [31:0] ALU_OUT,
  output logic [31:0] PC_DISP,
  output logic        PC_R,
  output logic        MEM_WE_ME,
  output logic        ME_WE,
  output logic        MEM_REG_ME,
  output logic [4:0]  RD
);
  logic [31:0] a, rs2, b, imm_i, imm_s, imm_u, imm_b, alu_d, pc_disp_d;
  logic [31:0] alu_q, pc_disp_q;
  logic        pc_r_d, pc_r_q, mem_we_q, me_we_q, mem_reg_q;
  logic [4:0]  rd_q;
`ifdef EXECUTE_FWD_EN
  assign a   = HU_RS1 == 2'b01 ? BP_MEM : HU_RS1 == 2'b10 ? BP_WB : D1;
  assign rs2 = HU_RS2 == 2'b01 ? BP_MEM : HU_RS2 == 2'b10 ? BP_WB : D2;
`else
  logic unused_fwd;
  assign unused_fwd = ^{HU_RS1, HU_RS2, BP_MEM, BP_WB};
  assign a   = D1;
  assign rs2 = D2;
`endif
  assign imm_i = {{20{Imm[24]}}, Imm[24:13]};
  assign imm_s = {{20{Imm[24]}}, Imm[24:18], Imm[4:0]};
  assign imm_u = {Imm[24:5], 12'b0};
  assign imm_b = {{19{Imm[24]}}, Imm[24], Imm[0], Imm[23:18], Imm[4:1], 1'b0};
  always_comb begin
    b = ALU_SRC2 == 2'b00 ? rs2 : ALU_SRC2 == 2'b01 ? imm_i : ALU_SRC2 == 2'b10 ? imm_s : imm_u;
    alu_d = ALU_CONTROL == 3'b000 ? a + b :
            ALU_CONTROL == 3'b001 ? a - b :
            ALU_CONTROL == 3'b010 ? a & b :
            ALU_CONTROL == 3'b011 ? a | b :
            ALU_CONTROL == 3'b100 ? a ^ b :
            ALU_CONTROL == 3'b101 ? a << b[4:0] :
            ALU_CONTROL == 3'b110 ? a >> b[4:0] :
            {31'b0, $signed(a) < $signed(b)};
    pc_r_d    = BRN_COND & (a == rs2);
    pc_disp_d = PC_EX + imm_b;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q     <= '0;
      pc_disp_q <= '0;
      pc_r_q    <= 1'b0;
      mem_we_q  <= 1'b0;
      me_we_q   <= 1'b0;
      mem_reg_q <= 1'b0;
      rd_q      <= '0;
    end else begin
      alu_q     <= alu_d;
      pc_disp_q <= pc_disp_d;
      pc_r_q    <= pc_r_d;
      mem_we_q  <= MEM_WE;
      me_we_q   <= DE_WE;
      mem_reg_q <= MEM_REG;
      rd_q      <= Imm[4:0];
    end
  end
  assign ALU_OUT    = alu_q;
  assign PC_DISP    = pc_disp_q;
  assign PC_R       = pc_r_q;
  assign MEM_WE_ME  = mem_we_q;
  assign ME_WE      = me_we_q;
  assign MEM_REG_ME = mem_reg_q;
  assign RD         = rd_q;
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed-vector self-checking bench for execute_stage
module tb_execute_stage;
  logic        clk = 1'b0, rst;
  logic [2:0]  ALU_CONTROL;
  logic [1:0]  ALU_SRC2, HU_RS1, HU_RS2;
  logic        BRN_COND, MEM_WE, DE_WE, MEM_REG;
  logic [31:0] D1, D2, PC_EX, BP_MEM, BP_WB;
  logic [24:0] Imm;
  logic [31:0] ALU_OUT, PC_DISP;
  logic        PC_R, MEM_WE_ME, ME_WE, MEM_REG_ME;
  logic [4:0]  RD;
  int errors = 0, checks = 0;
  execute_stage dut (
    .clk(clk), .rst(rst), .ALU_CONTROL(ALU_CONTROL), .ALU_SRC2(ALU_SRC2),
    .BRN_COND(BRN_COND), .MEM_WE(MEM_WE), .DE_WE(DE_WE), .MEM_REG(MEM_REG),
    .D1(D1), .D2(D2), .Imm(Imm), .PC_EX(PC_EX), .HU_RS1(HU_RS1), .HU_RS2(HU_RS2),
    .BP_MEM(BP_MEM), .BP_WB(BP_WB), .ALU_OUT(ALU_OUT), .PC_DISP(PC_DISP),
    .PC_R(PC_R), .MEM_WE_ME(MEM_WE_ME), .ME_WE(ME_WE), .MEM_REG_ME(MEM_REG_ME), .RD(RD)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, ".alu"}, ALU_OUT, 0);
    chk({tag, ".pc_disp"}, PC_DISP, 0);
    chk({tag, ".ctl"}, {27'b0, PC_R, MEM_WE_ME, ME_WE, MEM_REG_ME, 1'b0}, 0);
    chk({tag, ".rd"}, {27'b0, RD}, 0);
  endtask
  initial begin
    rst = 1'b1; ALU_CONTROL = 0; ALU_SRC2 = 0; BRN_COND = 0; MEM_WE = 0; DE_WE = 0; MEM_REG = 0;
    D1 = 0; D2 = 0; Imm = 0; PC_EX = 0; HU_RS1 = 0; HU_RS2 = 0; BP_MEM = 0; BP_WB = 0;
    step();
    chk_all_zero("reset1");
    step();
    chk_all_zero("reset2");
    rst = 1'b0;
    // addi x5,x0,5 : bits[31:7] of 0x00500293
    Imm = 25'h000A005; ALU_SRC2 = 2'b01; DE_WE = 1'b1; D1 = 0;
    step();
    chk("addi.alu", ALU_OUT, 5);
    chk("addi.rd", {27'b0, RD}, 5);
    chk("addi.me_we", {31'b0, ME_WE}, 1);
    chk("addi.pc_r", {31'b0, PC_R}, 0);
    // beq taken, B-imm +16
    DE_WE = 0; ALU_SRC2 = 2'b00; ALU_CONTROL = 3'b001; BRN_COND = 1;
    D1 = 7; D2 = 7; Imm = 25'h0000010; PC_EX = 32'h100;
    step();
    chk("beq_t.pc_r", {31'b0, PC_R}, 1);
    chk("beq_t.pc_disp", PC_DISP, 32'h110);
    chk("beq_t.alu", ALU_OUT, 0);
    chk("beq_t.me_we", {31'b0, ME_WE}, 0);
    D2 = 8;
    step();
    chk("beq_nt.pc_r", {31'b0, PC_R}, 0);
    chk("beq_nt.pc_disp", PC_DISP, 32'h110);
    chk("beq_nt.alu", ALU_OUT, 32'hFFFFFFFF);
    // B-imm -2 from PC 0 wraps
    D2 = 7; Imm = 25'h1FC001F; PC_EX = 0;
    step();
    chk("beq_neg.pc_disp", PC_DISP, 32'hFFFFFFFE);
    chk("beq_neg.pc_r", {31'b0, PC_R}, 1);
    // forwarding selects
    BRN_COND = 0; Imm = 0; HU_RS1 = 2'b01; BP_MEM = 32'h10; D1 = 32'h100; D2 = 3;
    step();
`ifdef EXECUTE_FWD_EN
    chk("fwd_mem.alu", ALU_OUT, 32'hD);
`else
    chk("nofwd_mem.alu", ALU_OUT, 32'hFD);
`endif
    HU_RS1 = 2'b11; HU_RS2 = 2'b10; BP_WB = 5; D1 = 9; D2 = 1; ALU_CONTROL = 3'b000;
    step();
`ifdef EXECUTE_FWD_EN
    chk("fwd_wb.alu", ALU_OUT, 14);
`else
    chk("nofwd_wb.alu", ALU_OUT, 10);
`endif
    HU_RS1 = 0; HU_RS2 = 0;
    // slt signed and add wrap, B = I-imm 1
    D1 = 32'hFFFFFFFF; Imm = 25'h0002000; ALU_SRC2 = 2'b01; ALU_CONTROL = 3'b111;
    step();
    chk("slt.alu", ALU_OUT, 1);
    ALU_CONTROL = 3'b000;
    step();
    chk("add_wrap.alu", ALU_OUT, 0);
    // shifts with rs2, only B[4:0] used
    Imm = 0; ALU_SRC2 = 2'b00; D1 = 1; D2 = 32'h24; ALU_CONTROL = 3'b101;
    step();
    chk("sll.alu", ALU_OUT, 32'h10);
    D1 = 32'h80000000; D2 = 31; ALU_CONTROL = 3'b110;
    step();
    chk("srl.alu", ALU_OUT, 1);
    D1 = 32'hF0F0; D2 = 32'hFF00; ALU_CONTROL = 3'b010;
    step();
    chk("and.alu", ALU_OUT, 32'hF000);
    ALU_CONTROL = 3'b011;
    step();
    chk("or.alu", ALU_OUT, 32'hFFF0);
    ALU_CONTROL = 3'b100;
    step();
    chk("xor.alu", ALU_OUT, 32'h0FF0);
    // S-imm -4
    D1 = 32'h100; Imm = 25'h1FC001C; ALU_SRC2 = 2'b10; ALU_CONTROL = 3'b000;
    step();
    chk("simm.alu", ALU_OUT, 32'hFC);
    chk("simm.rd", {27'b0, RD}, 5'h1C);
    // U-imm
    D1 = 0; Imm = 25'h02468A0; ALU_SRC2 = 2'b11;
    step();
    chk("uimm.alu", ALU_OUT, 32'h12345000);
    // MEM_WE / MEM_REG single-cycle pulse
    Imm = 0; ALU_SRC2 = 0; MEM_WE = 1; MEM_REG = 1;
    step();
    chk("pulse_hi.mem_we", {31'b0, MEM_WE_ME}, 1);
    chk("pulse_hi.mem_reg", {31'b0, MEM_REG_ME}, 1);
    MEM_WE = 0; MEM_REG = 0;
    step();
    chk("pulse_lo.mem_we", {31'b0, MEM_WE_ME}, 0);
    chk("pulse_lo.mem_reg", {31'b0, MEM_REG_ME}, 0);
    // reset wins over valid inputs, then capture resumes
    rst = 1; D1 = 7; D2 = 7; BRN_COND = 1; MEM_WE = 1; MEM_REG = 1; DE_WE = 1;
    Imm = 25'h0000010; PC_EX = 32'h200; ALU_CONTROL = 3'b000;
    step();
    chk_all_zero("rst_wins");
    rst = 0;
    step();
    chk("post_rst.alu", ALU_OUT, 14);
    chk("post_rst.pc_disp", PC_DISP, 32'h210);
    chk("post_rst.ctl", {28'b0, PC_R, MEM_WE_ME, ME_WE, MEM_REG_ME}, 4'hF);
    chk("post_rst.rd", {27'b0, RD}, 16);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
